// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator subsystem (logarithm and exponential).
// Contents:
//   - fixed-point widths of the input operand and of the internal fraction
//   - FSM state encodings used by the iterative accelerators
//   - ln_lut(): the ln(1+2^-i) constant table, i = 0..17, at FW fraction bits
package accel_pkg;

   localparam int IN_INT    = 2;                   // integer bits of the input
   localparam int IN_FRAC   = 16;                  // fraction bits of input/output
   localparam int LUT_GUARD = 6;                   // guard bits the table is built for
   localparam int FW        = IN_FRAC + LUT_GUARD; // internal fraction width (22)
   localparam int LUT_LEN   = 18;                  // number of table entries

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // ln(1+2^-i) * 2^FW, rounded to nearest. Entries past the end read as 0,
   // so running more iterations than the table covers is harmless.
   function automatic logic [FW-1:0] ln_lut(input int unsigned i);
      logic [FW-1:0] v;
      case (i)
         0:       v = 22'd2907270;
         1:       v = 22'd1700644;
         2:       v = 22'd935932;
         3:       v = 22'd494018;
         4:       v = 22'd254278;
         5:       v = 22'd129066;
         6:       v = 22'd65029;
         7:       v = 22'd32641;
         8:       v = 22'd16352;
         9:       v = 22'd8184;
         10:      v = 22'd4094;
         11:      v = 22'd2048;
         12:      v = 22'd1024;
         13:      v = 22'd512;
         14:      v = 22'd256;
         15:      v = 22'd128;
         16:      v = 22'd64;
         17:      v = 22'd32;
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/ln_rom.sv
// Combinational ROM returning ln(1+2^-idx) as an unsigned 0.OUT_FW fraction.
// Ports:
//   idx  in   iteration index
//   lut  out  table entry, rescaled from the package width FW to OUT_FW
module ln_rom
   import accel_pkg::*;
#(
   parameter int IW     = 5,
   parameter int OUT_FW = FW
) (
   input  logic [IW-1:0]     idx,
   output logic [OUT_FW-1:0] lut
);

   logic [FW-1:0] raw;

   assign raw = ln_lut(32'(idx));

   generate
      if (OUT_FW == FW) begin : g_same
         assign lut = raw;
      end else if (OUT_FW > FW) begin : g_wider
         assign lut = {raw, {(OUT_FW-FW){1'b0}}};
      end else begin : g_narrower
         // Round to nearest when dropping guard bits; entries are all < 0.7,
         // so the rounding add cannot carry out of FW bits.
         localparam int SH = FW - OUT_FW;
         localparam logic [FW-1:0] HALF = FW'(1) << (SH - 1);
         assign lut = OUT_FW'((raw + HALF) >> SH);
      end
   endgenerate

endmodule

// File: rtl/log_accelerator.sv
// Iterative shift-and-add natural logarithm: x = ln(y) for y in unsigned 2.16,
// result as an unsigned 0.16 fraction.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-low
//   start     in   request pulse, sampled only while idle
//   intpart   in   integer part of y (2 bits)
//   fracpart  in   fractional part of y (16 bits)
//   busy      out  high from the accepted start until done deasserts
//   done      out  one-cycle completion pulse; x/invalid valid from then on
//   x         out  ln(y) in 0.16, held until the next accepted start
//   invalid   out  y < 1 or y >= e; qualified by done, held with x
//   fsm_state out  current FSM state (IDLE/ITER/DONE encodings from accel_pkg)
// Handshake: start is accepted on a rising edge only when fsm_state == IDLE;
// there is no back-pressure. done pulses for exactly one cycle and the result
// stays on x/invalid until the next accepted start.
module log_accelerator
   import accel_pkg::*;
#(
   parameter int ITERS = LUT_LEN,
   parameter int GUARD = LUT_GUARD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [IN_INT-1:0]  intpart,
   input  logic [IN_FRAC-1:0] fracpart,
   output logic               busy,
   output logic               done,
   output logic [IN_FRAC-1:0] x,
   output logic               invalid,
   output logic [1:0]         fsm_state
);

   localparam int FRAC_W = IN_FRAC + GUARD;
   localparam int YW     = 1 + IN_INT + FRAC_W;   // 3.FRAC_W
   localparam int IW     = $clog2(ITERS + 1);
   localparam logic [YW-1:0]     P_ONE = YW'(1) << FRAC_W;
   localparam logic [FRAC_W:0]   HALF  = (FRAC_W+1)'(1) << (GUARD - 1);

   logic [1:0]        state;
   logic [YW-1:0]     y_reg;   // target, 3.FRAC_W
   logic [YW-1:0]     p_reg;   // running product of (1+2^-i) factors, 3.FRAC_W
   logic [FRAC_W:0]   a_reg;   // accumulated log, 1.FRAC_W (int bit flags >= 1.0)
   logic [IW-1:0]     iter;
   logic [FRAC_W-1:0] lut;
   logic [YW:0]       t_sum;
   logic              take;
   logic [IN_FRAC:0]  x_rnd;

   ln_rom #(.IW(IW), .OUT_FW(FRAC_W)) u_rom (
      .idx (iter),
      .lut (lut)
   );

   // Candidate product; one extra bit so the compare sees any carry.
   assign t_sum = {1'b0, p_reg} + {1'b0, (p_reg >> iter)};
   assign take  = (t_sum <= {1'b0, y_reg});

   // Round-half-up of A to 16 fraction bits; bit IN_FRAC is the carry used
   // for saturation.
   assign x_rnd = (IN_FRAC+1)'(({1'b0, a_reg[FRAC_W-1:0]} + HALF) >> GUARD);

   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         y_reg   <= '0;
         p_reg   <= '0;
         a_reg   <= '0;
         iter    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         x       <= '0;
         invalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Also the cycle after a result: done drops here and a new
               // request may be taken on the same edge.
               done <= 1'b0;
               busy <= start;
               if (start) begin
                  y_reg <= {1'b0, intpart, fracpart, {GUARD{1'b0}}};
                  p_reg <= P_ONE;
                  a_reg <= '0;
                  iter  <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               if (take) begin
                  p_reg <= t_sum[YW-1:0];
                  a_reg <= a_reg + {1'b0, lut};
               end
               iter <= iter + 1'b1;
               if (iter == IW'(ITERS - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (y_reg[YW-2 -: IN_INT] == '0) begin
                  x       <= '0;
                  invalid <= 1'b1;
               end else if (a_reg[FRAC_W]) begin
                  x       <= '1;
                  invalid <= 1'b1;
               end else begin
                  x       <= x_rnd[IN_FRAC] ? '1 : x_rnd[IN_FRAC-1:0];
                  invalid <= 1'b0;
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_log_accelerator.sv
module tb_log_accelerator;
   import accel_pkg::*;

   localparam real E_CONST = 2.718281828459045;
   localparam int  LAT     = 19;
   localparam int  TIMEOUT = 60;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  intpart;
   logic [15:0] fracpart;
   logic        busy;
   logic        done;
   logic [15:0] x;
   logic        invalid;
   logic [1:0]  fsm_state;

   logic [16:0] exp_q[$];   // {invalid, x}
   int n_vec  = 0;
   int n_fail = 0;

   log_accelerator dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .intpart   (intpart),
      .fracpart  (fracpart),
      .busy      (busy),
      .done      (done),
      .x         (x),
      .invalid   (invalid),
      .fsm_state (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: round(ln(y) * 65536) with range handling
   function automatic logic [16:0] model_x(input logic [1:0] ip, input logic [15:0] fr);
      real y;
      real r;
      int  v;
      if (ip == 2'd0) return {1'b1, 16'h0000};
      y = real'(ip) + real'(fr) / 65536.0;
      if (y >= E_CONST) return {1'b1, 16'hFFFF};
      r = $ln(y) * 65536.0;
      v = $rtoi(r + 0.5);
      if (v > 65535) v = 65535;
      return {1'b0, v[15:0]};
   endfunction

   // driver: called at a negedge; start is sampled at the next posedge
   task automatic drive_start(input logic [1:0] ip, input logic [15:0] fr);
      intpart  = ip;
      fracpart = fr;
      start    = 1'b1;
      exp_q.push_back(model_x(ip, fr));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // waits for done, checking latency and busy; cyc0 = cycles already elapsed
   task automatic wait_done(input string tag, input int cyc0);
      int cyc     = cyc0;
      bit busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < TIMEOUT) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      n_vec++;
      assert (cyc < TIMEOUT) else begin
         n_fail++;
         $error("FAIL %s_timeout observed=%0d cycles expected=done", tag, cyc);
      end
      n_vec++;
      assert (cyc === LAT) else begin
         n_fail++;
         $error("FAIL %s_latency observed=%0d expected=%0d", tag, cyc, LAT);
      end
      n_vec++;
      assert ((busy_ok && busy === 1'b1) === 1'b1) else begin
         n_fail++;
         $error("FAIL %s_busy observed=%0b expected=1", tag, busy_ok);
      end
   endtask

   // scoreboard: pop expected and compare against the DUT result
   task automatic check_result(input string tag, input int tol);
      logic [16:0] e;
      int d;
      n_vec++;
      assert (exp_q.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0;
      n_vec++;
      assert (invalid === e[16]) else begin
         n_fail++;
         $error("FAIL %s_invalid observed=%0b expected=%0b", tag, invalid, e[16]);
      end
      n_vec++;
      if (e[16]) begin
         assert (x === e[15:0]) else begin
            n_fail++;
            $error("FAIL %s_x observed=%h expected=%h", tag, x, e[15:0]);
         end
      end else begin
         d = int'(x) - int'(e[15:0]);
         if (d < 0) d = -d;
         assert (((d <= tol) && !$isunknown(x)) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s_x observed=%h expected=%h+-%0d", tag, x, e[15:0], tol);
         end
      end
   endtask

   // next cycle after done: pulse ends and block goes idle
   task automatic finish_pulse(input string tag);
      @(negedge clk);
      n_vec++;
      assert ((done === 1'b0) && (busy === 1'b0)) else begin
         n_fail++;
         $error("FAIL %s_pulse observed=done%0b/busy%0b expected=done0/busy0", tag, done, busy);
      end
   endtask

   task automatic run_one(input string tag, input logic [1:0] ip, input logic [15:0] fr,
                          input int tol);
      drive_start(ip, fr);
      wait_done(tag, 0);
      check_result(tag, tol);
      finish_pulse(tag);
   endtask

   initial begin
      logic [1:0]  rip;
      logic [15:0] rfr;
      bit          saw_done;

      rst      = 1'b0;
      start    = 1'b0;
      intpart  = 2'd0;
      fracpart = 16'h0;
      repeat (3) @(negedge clk);

      // reset state
      n_vec++;
      assert ((busy === 1'b0) && (done === 1'b0)) else begin
         n_fail++;
         $error("FAIL rst_flags observed=busy%0b/done%0b expected=0/0", busy, done);
      end
      n_vec++;
      assert ((x === 16'h0000) && (invalid === 1'b0)) else begin
         n_fail++;
         $error("FAIL rst_result observed=%h/%0b expected=0000/0", x, invalid);
      end
      n_vec++;
      assert (fsm_state === IDLE) else begin
         n_fail++;
         $error("FAIL rst_state observed=%0d expected=%0d", fsm_state, IDLE);
      end
      rst = 1'b1;
      @(negedge clk);

      // directed values
      run_one("y1p0",  2'b01, 16'h0000, 0);
      run_one("y2p0",  2'b10, 16'h0000, 2);
      run_one("y_e074", 2'b10, 16'h1888, 2);
      run_one("y_e020", 2'b01, 16'h38AE, 2);
      run_one("roundtrip", 2'b01, 16'h38AE, 3);

      // out of range, then a valid request clears invalid
      run_one("lt_one", 2'b00, 16'h8000, 0);
      run_one("y3p0",  2'b11, 16'h0000, 0);
      run_one("clear", 2'b01, 16'h8000, 2);

      // random in-range values
      for (int k = 0; k < 6; k++) begin
         rip = 2'($urandom_range(1, 2));
         rfr = (rip == 2'b01) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 16'hB000));
         run_one("rand", rip, rfr, 2);
      end

      // start re-pulsed during busy is ignored
      drive_start(2'b01, 16'h4000);
      repeat (4) @(negedge clk);
      intpart  = 2'b11;
      fracpart = 16'hFFFF;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      intpart  = 2'b00;
      fracpart = 16'h1234;
      wait_done("repulse", 5);
      check_result("repulse", 2);

      // back-to-back: new start while done is high
      drive_start(2'b10, 16'h5000);
      n_vec++;
      assert ((done === 1'b0) && (busy === 1'b1)) else begin
         n_fail++;
         $error("FAIL b2b_accept observed=done%0b/busy%0b expected=done0/busy1", done, busy);
      end
      wait_done("b2b", 0);
      check_result("b2b", 2);
      finish_pulse("b2b");

      // asynchronous reset mid-iteration
      drive_start(2'b10, 16'h3000);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      assert ((busy === 1'b0) && (done === 1'b0) && (x === 16'h0000) && (invalid === 1'b0))
      else begin
         n_fail++;
         $error("FAIL async_rst observed=busy%0b/done%0b/x%h/inv%0b expected=0/0/0000/0",
                busy, done, x, invalid);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      saw_done = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      n_vec++;
      assert (saw_done === 1'b0) else begin
         n_fail++;
         $error("FAIL abort_no_done observed=%0b expected=0", saw_done);
      end
      run_one("after_rst", 2'b01, 16'h2000, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
